clock_display: RTL and testbench

Time-of-day counter and six-digit seven-segment scan driver, fed by the tick divider's single-cycle enable pulses. Keeps HH:MM:SS in BCD and advances once per 1 Hz tick. Two button inputs set the time. The selected field blinks at 2 Hz, and the digits are multiplexed at 1 kHz onto the board display.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/btn_sync_edge.sv | 25 ++
 rtl/clock_display.sv | 94 +++++++++
 tb/tb_clock_display.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encoding, digit count, segment patterns and BCD limits for clock_display
package clock_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} mode_e;
  localparam int NDIG = 6;
  localparam logic [3:0] TENS_MAX = 4'd5;
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] HOUR_TENS_MAX = 4'd2;
  localparam logic [3:0] HOUR_ONES_MAX = 4'd3;
  localparam logic [7:0] MS_LAST = {TENS_MAX, ONES_MAX};
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Active-low {dp,g,f,e,d,c,b,a}; codes 10..15 are blank.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  // Two-digit BCD increment that wraps to 00 after the given last value.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] last);
    return v == last ? 8'h00 : v[3:0] == ONES_MAX ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer plus rising-edge detector for a raw button level
//   high  - system clock
//   rst_n - asynchronous active-low reset
//   din   - raw asynchronous level
//   pulse - one-cycle pulse per rising edge of the synchronized level
module btn_sync_edge (
  input  logic high,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic s1_q, s2_q, prev_q;
  always_ff @(posedge high or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign pulse = s2_q & ~prev_q;
endmodule

// File: rtl/clock_display.sv
// clock_display: BCD time-of-day counter with button setting, field blink and 6-digit scan driver
//   high      - 100 MHz system clock
//   rst_n     - asynchronous active-low reset
//   tick_*    - single-cycle enables at 1 Hz, 2 Hz and 1 kHz
//   btn_mode  - raw button, advances RUN->SET_H->SET_M->SET_S->RUN
//   btn_inc   - raw button, increments the selected field in a SET mode
//   seg/an    - registered active-low segments and digit enables (bit 0 = seconds ones)
//   bcd_time  - {h_t,h_o,m_t,m_o,s_t,s_o}
//   mode      - current mode
module clock_display
  import clock_pkg::*;
#(
  parameter int HOUR_MAX_TENS = 2,
  parameter int NDIG = clock_pkg::NDIG
) (
  input  logic            high,
  input  logic            rst_n,
  input  logic            tick_1hz,
  input  logic            tick_2hz,
  input  logic            tick_1khz,
  input  logic            btn_mode,
  input  logic            btn_inc,
  output logic [7:0]      seg,
  output logic [NDIG-1:0] an,
  output logic [23:0]     bcd_time,
  output logic [1:0]      mode
);
  localparam logic [7:0] HOUR_LAST = {4'(HOUR_MAX_TENS), HOUR_ONES_MAX};
  localparam logic [2:0] IDX_LAST = 3'(NDIG - 1);
  localparam logic [NDIG-1:0] ONE = NDIG'(1);
  mode_e mode_q, mode_d;
  logic blink_q, blink_d;
  logic [7:0] h_q, h_d, m_q, m_d, s_q, s_d;
  logic [2:0] idx_q, idx_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;
  logic mode_p, inc_p, blank;
  logic [3:0] dig;
  btn_sync_edge u_mode (.high(high), .rst_n(rst_n), .din(btn_mode), .pulse(mode_p));
  btn_sync_edge u_inc  (.high(high), .rst_n(rst_n), .din(btn_inc),  .pulse(inc_p));
  assign bcd_time = {h_q, m_q, s_q};
  assign mode = mode_q;
  assign an = an_q;
  assign seg = seg_q;
  // Time counters, mode and blink. Ticks only count in RUN, which also drops a
  // tick coincident with SET_S->RUN; a mode edge suppresses a same-cycle inc.
  always_comb begin
    mode_d  = mode_p ? mode_e'(mode_q + 2'd1) : mode_q;
    blink_d = mode_p ? 1'b0 : blink_q ^ tick_2hz;
    h_d = h_q;
    m_d = m_q;
    s_d = s_q;
    if (mode_q == RUN) begin
      if (tick_1hz) begin
        s_d = bcd2_inc(s_q, MS_LAST);
        m_d = s_q == MS_LAST ? bcd2_inc(m_q, MS_LAST) : m_q;
        h_d = s_q == MS_LAST && m_q == MS_LAST ? bcd2_inc(h_q, HOUR_LAST) : h_q;
      end
    end else if (inc_p && !mode_p) begin
      h_d = mode_q == SET_H ? bcd2_inc(h_q, HOUR_LAST) : h_q;
      m_d = mode_q == SET_M ? bcd2_inc(m_q, MS_LAST) : m_q;
      s_d = mode_q == SET_S ? bcd2_inc(s_q, MS_LAST) : s_q;
    end
  end
  // Scan: digit pairs map idx[2:1] = 0/1/2 to s/m/h, so the selected pair is 3 - mode.
  always_comb begin
    idx_d = tick_1khz ? (idx_q == IDX_LAST ? 3'd0 : idx_q + 3'd1) : idx_q;
    dig   = 4'(bcd_time >> {idx_q, 2'b00});
    blank = mode_q != RUN && blink_q && idx_q[2:1] == 2'd3 - mode_q;
    an_d  = ~(ONE << idx_q);
    seg_d = blank ? SEG_BLANK : {~(idx_q == 3'd2 || idx_q == 3'd4), SEG_LUT[dig][6:0]};
  end
  always_ff @(posedge high or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= RUN;
      blink_q <= 1'b0;
      h_q     <= 8'h00;
      m_q     <= 8'h00;
      s_q     <= 8'h00;
      idx_q   <= 3'd0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      mode_q  <= mode_d;
      blink_q <= blink_d;
      h_q     <= h_d;
      m_q     <= m_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end
endmodule

// File: tb/tb_clock_display.sv
// tb_clock_display: scoreboard bench for clock_display against a seconds/minutes/hours reference model
module tb_clock_display;
  logic high = 1'b0, rst_n = 1'b0;
  logic tick_1hz = 1'b0, tick_2hz = 1'b0, tick_1khz = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0;
  logic [7:0] seg;
  logic [5:0] an;
  logic [23:0] bcd_time;
  logic [1:0] mode;
  clock_display dut (
    .high(high), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_1khz(tick_1khz),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .seg(seg), .an(an), .bcd_time(bcd_time), .mode(mode)
  );
  always #5 high = ~high;
  typedef struct {
    string       name;
    logic [23:0] bcd;
    logic [1:0]  md;
    bit          full;
    logic [5:0]  an;
    logic [7:0]  seg;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int h = 0, m = 0, s = 0, md = 0, idx = 0;
  bit blink = 1'b0;
  logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  function automatic logic [23:0] ref_bcd();
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
  function automatic logic [7:0] ref_seg();
    int vals [6];
    logic [7:0] v;
    bit sel;
    vals = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    sel = (md == 1 && idx >= 4) || (md == 2 && (idx == 2 || idx == 3)) || (md == 3 && idx <= 1);
    v = pat[vals[idx]];
    if (idx == 2 || idx == 4) v[7] = 1'b0;
    return (blink && sel) ? 8'hFF : v;
  endfunction
  function automatic logic [5:0] ref_an();
    logic [5:0] a;
    a = 6'h3F;
    a[idx] = 1'b0;
    return a;
  endfunction
  task automatic cyc();
    @(posedge high);
    #1;
  endtask
  task automatic push(input string nm, input bit full, input logic [5:0] a, input logic [7:0] sg,
                      input logic [23:0] b, input logic [1:0] mo);
    exp_t e;
    e.name = nm; e.full = full; e.an = a; e.seg = sg; e.bcd = b; e.md = mo;
    q.push_back(e);
  endtask
  task automatic chk(input string nm, input bit full);
    if (full) cyc();
    push(nm, full, ref_an(), ref_seg(), ref_bcd(), 2'(md));
    cyc();
  endtask
  task automatic advance();
    s++;
    if (s == 60) begin
      s = 0;
      m++;
      if (m == 60) begin
        m = 0;
        h = (h + 1) % 24;
      end
    end
  endtask
  task automatic pulse(input int w);
    if (w == 0) tick_1hz = 1'b1;
    else if (w == 1) tick_2hz = 1'b1;
    else tick_1khz = 1'b1;
    cyc();
    tick_1hz = 1'b0; tick_2hz = 1'b0; tick_1khz = 1'b0;
    if (w == 0 && md == 0) advance();
    else if (w == 1) blink = !blink;
    else if (w == 2) idx = (idx + 1) % 6;
  endtask
  task automatic press(input bit pm, input bit pi, input bit tk, input int hold);
    btn_mode = pm; btn_inc = pi;
    cyc();
    cyc();
    push("btn_pre", 1'b0, 6'h00, 8'h00, ref_bcd(), 2'(md));
    tick_1hz = tk;
    cyc();
    tick_1hz = 1'b0;
    if (tk && md == 0) advance();
    if (pm) begin
      md = (md + 1) % 4;
      blink = 1'b0;
    end else if (pi && md == 1) h = (h + 1) % 24;
    else if (pi && md == 2) m = (m + 1) % 60;
    else if (pi && md == 3) s = (s + 1) % 60;
    push("btn_act", 1'b0, 6'h00, 8'h00, ref_bcd(), 2'(md));
    repeat (hold) cyc();
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) cyc();
  endtask
  always @(negedge high) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (bcd_time !== e.bcd || mode !== e.md) begin
        n_fail++;
        $display("FAIL %s: bcd_time=%h mode=%0d, expected bcd_time=%h mode=%0d", e.name, bcd_time, mode, e.bcd, e.md);
      end
      if (e.full) begin
        n_chk++;
        if (an !== e.an || seg !== e.seg) begin
          n_fail++;
          $display("FAIL %s: an=%b seg=%h, expected an=%b seg=%h", e.name, an, seg, e.an, e.seg);
        end
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end
  initial begin
    int op;
    repeat (2) cyc();
    push("reset_state", 1'b1, 6'h3F, 8'hFF, 24'h0, 2'd0);
    cyc();
    rst_n = 1'b1;
    chk("first_edge", 1'b1);
    pulse(0);
    chk("tick_latency", 1'b0);
    repeat (6) pulse(0);
    chk("count_7s", 1'b1);
    rst_n = 1'b0;
    repeat (3) begin
      push("rst_async", 1'b1, 6'h3F, 8'hFF, 24'h0, 2'd0);
      cyc();
    end
    rst_n = 1'b1;
    h = 0; m = 0; s = 0; md = 0; idx = 0; blink = 1'b0;
    chk("rst_release", 1'b1);
    press(1, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      press(0, 1, 0, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) pulse(0);
    end
    chk("set_h_wrap", 1'b1);
    repeat (23) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    repeat (59) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    repeat (59) press(0, 1, 0, 0);
    press(1, 0, 0, 1);
    chk("preload_235959", 1'b1);
    pulse(0);
    chk("rollover", 1'b1);
    press(1, 0, 0, 0);
    repeat (12) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    repeat (34) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    repeat (56) press(0, 1, 0, 0);
    repeat (3) press(1, 0, 0, 0);
    chk("at_123456_set_m", 1'b1);
    press(1, 1, 0, 0);
    chk("simul_buttons", 1'b1);
    press(1, 0, 1, 0);
    chk("drop_tick_on_run", 1'b1);
    pulse(0);
    chk("resume_count", 1'b1);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    while (idx != 2) pulse(2);
    pulse(1);
    chk("blink_idx2", 1'b1);
    pulse(2);
    chk("blink_idx3", 1'b1);
    pulse(2);
    chk("blink_idx4_vis", 1'b1);
    pulse(1);
    repeat (4) pulse(2);
    chk("blink_restored", 1'b1);
    for (int i = 0; i < 6; i++) begin
      pulse(2);
      chk("scan", 1'b1);
    end
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 6);
      if (op <= 2) pulse(op);
      else if (op == 3) press(1, 0, 0, $urandom_range(0, 4));
      else if (op == 4) press(0, 1, 0, $urandom_range(0, 4));
      else if (op == 5) press(1, 1, 0, $urandom_range(0, 4));
      else press(md == 3, md != 3, md == 3, $urandom_range(0, 4));
      chk("random", 1'b1);
    end
    repeat (3) cyc();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
